seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Dynamic-scan scheduler for the 6-digit common-anode 7-segment display.
//  Holds a tear-free shadow copy of 6 BCD/hex digits and a decimal-point mask.
//  Time-multiplexes the digits, producing the sel/seg pair consumed by the
//  74HC595 serial driver. New values are committed only at frame boundaries.
// PARAMETERS
//  SCAN_CNT  50_000  sys_clk cycles per digit slot (1 ms @ 50 MHz); must be >= 56
//  BLANK_LZ  1       1 = blank leading zeros on digits 5..1; 0 = show all digits
// PORTS
//  sys_clk     in   1   system clock
//  sys_rst_n   in   1   asynchronous, active-low reset
//  en          in   1   1 = scanning; 0 = display dark
//  load        in   1   1-cycle strobe: capture data_in/point_in into pending
//  data_in     in   24  6 nibbles; [3:0] = digit 0 (rightmost) .. [23:20] = digit 5
//  point_in    in   6   dp mask; bit i lights the dp of digit i
//  sel         out  6   one-hot digit select, active-high; bit i = digit i
//  seg         out  8   segments, active-low; {dp,g,f,e,d,c,b,a}
//  frame_done  out  1   1-cycle pulse when digit 5 slot ends (idx 5->0)
//  upd_done    out  1   1-cycle pulse when pending is committed to shadow
// BEHAVIOUR
//  Reset: sel=0, seg=8'hFF, frame_done=0, upd_done=0. Internal state also
//   clears: cnt=0, idx=0, shadow=0, pending=0, pend=0.
//  Slot counter: when en=1, cnt counts 0..SCAN_CNT-1 and wraps.
//   On wrap, idx advances 0,1..5,0. The 5->0 wrap asserts frame_done in the
//   same cycle as the idx update.
//  Outputs are registered; sel/seg reflect the new idx 1 cycle after it changes.
//   sel = 6'b1 << idx. seg = decode(shadow nibble idx), with seg[7] = ~dp bit.
//  Decode (gfedcba, active-low):
//   0..9 -> C0,F9,A4,B0,99,92,82,F8,80,90 (bit7 = 1)
//   A..F -> 88,83,C6,A1,86,8E
//  Leading-zero blank (BLANK_LZ=1): digit i>=1 shows seg=8'hFF when its nibble
//   and all higher nibbles are 0 AND its dp bit is 0. Digit 0 is never blanked.
//  Load: load=1 copies data_in/point_in into pending and sets pend.
//   A repeated load before commit overwrites pending (last wins).
//  Commit (en=1): in the frame_done cycle, if pend=1 then shadow<=pending,
//   pend<=0, and upd_done pulses.
//   If load arrives in that same cycle: shadow takes the OLD pending, pending
//   takes the new data, pend stays 1, and the commit happens next frame.
//  Commit (en=0): pend commits on the next cycle, with upd_done.
//  en=0: cnt=0 and idx=0 held; sel=0, seg=8'hFF one cycle after en falls.
//   On en rising, digit 0 is shown from the next cycle and a full slot begins.
//  Reset mid-operation clears everything immediately (async); no partial commit.
//  Slot >= 56 cycles, so each digit spans at least one full 14-bit x 4-clk
//   shift frame of the HC595 driver.
// TESTING (SCAN_CNT=60)
//  Reset while en=1 -> sel=0, seg=FF, no pulses until en has run >= 60 cycles.
//  load 24'h012345, pt=0, en=1 -> after commit sel walks 01,02,04..20 every
//   60 clks. Seg sequence: 92,99,B0,A4,F9,FF (digit5=0 blanked); frame_done every 360.
//  load 24'h000000, pt=6'b000100 -> digits 5,4,3 = FF; digit2 = 40; digits 1,0 = C0.
//  BLANK_LZ=0 with the same data -> digits 5,4,3 = C0.
//  Mid-frame load -> display unchanged until frame_done; upd_done in that cycle;
//   new digits appear from digit 0.
//  load coincident with frame_done while pend=1 -> old pending shown this frame,
//   new value next frame, 2 upd_done pulses total.
//  Hex 24'hABCDEF -> 8E,86,A1,C6,83,88.
//  en=0 then load -> upd_done next cycle, sel=0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan scheduler for a 6-digit common-anode 7-segment display. It keeps a
//   shadow copy of six hex digits and a decimal-point mask, and it shows one
//   digit per slot of SCAN_CNT clocks. New values first go into a pending
//   register. They move into the shadow only at a frame boundary, so one
//   frame never mixes old and new digits. When scanning is off, the pending
//   value is committed on the next cycle.
//
// Parameters
//   SCAN_CNT   clocks per digit slot (>= 56)
//   BLANK_LZ   1 = blank leading zero digits 5..1, 0 = show every digit
//
// Ports
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   en          in   1 = scanning, 0 = display dark
//   load        in   one-cycle strobe that captures data_in/point_in as pending
//   data_in     in   [3:0] = digit 0 (rightmost) .. [23:20] = digit 5
//   point_in    in   bit i lights the decimal point of digit i
//   sel         out  one-hot digit select, active-high
//   seg         out  {dp,g,f,e,d,c,b,a}, active-low
//   frame_done  out  one-cycle pulse when the digit 5 slot ends
//   upd_done    out  one-cycle pulse when pending is committed to the shadow
module seg_scan_ctrl #(
  parameter int SCAN_CNT = 50_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [23:0] data_in,
  input  logic [5:0]  point_in,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        upd_done
);

  localparam int            CW      = $clog2(SCAN_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CNT - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [23:0]   shadow_data;
  logic [5:0]    shadow_point;
  logic [23:0]   pend_data;
  logic [5:0]    pend_point;
  logic          pend;

  logic          slot_end;
  logic          frame_end;
  logic          commit;
  logic [3:0]    nib;
  logic          dp;
  logic          above;
  logic          blank;
  logic [7:0]    seg7;
  logic [7:0]    seg_next;

  assign slot_end  = en && (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 3'd5);
  // While scanning, commit waits for the frame boundary. While dark, it goes
  // through at once.
  assign commit    = pend && (!en || frame_end);

  // Slot counter and digit index. Both are held at zero while dark, so
  // enabling always starts with a full slot of digit 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pending and shadow registers. If a load lands in the same cycle as a
  // commit, the shadow takes the old pending value and the new data stays
  // pending for the next frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shadow_data  <= '0;
      shadow_point <= '0;
      pend_data    <= '0;
      pend_point   <= '0;
      pend         <= 1'b0;
      upd_done     <= 1'b0;
    end else begin
      upd_done <= commit;
      if (commit) begin
        shadow_data  <= pend_data;
        shadow_point <= pend_point;
      end
      if (load) begin
        pend_data  <= data_in;
        pend_point <= point_in;
      end
      pend <= load | (pend & ~commit);
    end
  end

  // Decode the current digit. A digit counts as a leading zero only when
  // neither it nor any higher digit has a non-zero nibble or a lit point.
  // So a lit point on a higher digit keeps the zeros below it visible.
  always_comb begin
    nib      = shadow_data[{idx, 2'b00} +: 4];
    dp       = shadow_point[idx];
    above    = 1'b0;
    seg7     = 8'hFF;
    blank    = 1'b0;
    seg_next = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if ((i >= int'(idx)) && ((shadow_data[4*i +: 4] != 4'h0) || shadow_point[i])) begin
        above = 1'b1;
      end
    end
    case (nib)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
    blank    = BLANK_LZ && (idx != 3'd0) && !above;
    seg_next = blank ? 8'hFF : (seg7 & {~dp, 7'h7F});
  end

  // Registered outputs. They follow idx one cycle later and go dark one
  // cycle after en falls.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= 8'hFF;
    end else if (!en) begin
      sel <= '0;
      seg <= 8'hFF;
    end else begin
      sel <= 6'b1 << idx;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Scoreboard bench for seg_scan_ctrl with SCAN_CNT=60. It drives two
//   instances from the same stimulus: one with leading-zero blanking and one
//   without. Stimulus tasks push the expected display changes and the
//   expected frame/update pulses, each tagged with the clock edge on which it
//   must appear. A separate monitor pops an entry and compares it whenever an
//   instance changes its display or pulses.
module tb_seg_scan_ctrl;

  localparam int SCAN  = 60;
  localparam int FRAME = 6 * SCAN;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    int         cyc;
    logic [5:0] sel;
    logic [7:0] seg;
    logic [7:0] seg_nb;
  } disp_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        en;
  logic        load;
  logic [23:0] data_in;
  logic [5:0]  point_in;
  logic [5:0]  sel, sel_nb;
  logic [7:0]  seg, seg_nb;
  logic        frame_done, frame_done_nb;
  logic        upd_done, upd_done_nb;

  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          mon_on = 1'b0;
  logic [13:0] prev_disp = 14'h00FF;
  disp_t       disp_q[$];
  int          frame_q[$];
  int          upd_q[$];
  disp_t       exp_d;
  int          exp_c;

  // Reference state: what the display should hold, and what is pending.
  logic [23:0] m_sh_d, m_pd_d;
  logic [5:0]  m_sh_p, m_pd_p;
  bit          m_pend;

  seg_scan_ctrl #(.SCAN_CNT(SCAN), .BLANK_LZ(1'b1)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .load(load),
    .data_in(data_in), .point_in(point_in), .sel(sel), .seg(seg),
    .frame_done(frame_done), .upd_done(upd_done));

  seg_scan_ctrl #(.SCAN_CNT(SCAN), .BLANK_LZ(1'b0)) u_dut_nb (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .load(load),
    .data_in(data_in), .point_in(point_in), .sel(sel_nb), .seg(seg_nb),
    .frame_done(frame_done_nb), .upd_done(upd_done_nb));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] actual);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: unexpected event with value %0h, expected none (edge %0d)", name, actual, cyc);
  endtask

  // Expected pattern for digit i. With blanking on, a digit is blank when it
  // lies above the highest digit that has a non-zero nibble or a lit point.
  function automatic logic [7:0] exp_seg(input logic [23:0] d, input logic [5:0] p,
                                         input int i, input bit blank_lz);
    int top = 0;
    logic [3:0] n;
    for (int j = 0; j < 6; j++)
      if (d[4*j +: 4] != 4'h0 || p[j]) top = j;
    if (blank_lz && i > top) return 8'hFF;
    n = d[4*i +: 4];
    return SEG_TABLE[n] & (p[i] ? 8'h7F : 8'hFF);
  endfunction

  function automatic logic [23:0] rand_data();
    logic [23:0] mask;
    mask = 24'hFFFFFF >> (4 * $urandom_range(0, 6));
    return 24'($urandom()) & mask;
  endfunction

  function automatic logic [5:0] rand_point();
    return ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'h00;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_commit();
    m_sh_d = m_pd_d;
    m_sh_p = m_pd_p;
    m_pend = 1'b0;
  endtask

  task automatic push_disp(input int c, input logic [5:0] s, input int k);
    disp_t e;
    e.cyc    = c;
    e.sel    = s;
    e.seg    = (s == 6'h00) ? 8'hFF : exp_seg(m_sh_d, m_sh_p, k, 1'b1);
    e.seg_nb = (s == 6'h00) ? 8'hFF : exp_seg(m_sh_d, m_sh_p, k, 1'b0);
    disp_q.push_back(e);
  endtask

  // Load while dark. The pending value commits on the next edge.
  task automatic applyStimulus(input logic [23:0] d, input logic [5:0] p);
    data_in  = d;
    point_in = p;
    load     = 1'b1;
    if (m_pend) begin
      model_commit();
      upd_q.push_back(cyc + 1);
    end
    m_pd_d = d;
    m_pd_p = p;
    m_pend = 1'b1;
    tick();
    load = 1'b0;
    upd_q.push_back(cyc + 1);
    model_commit();
    tick();
    tick();
  endtask

  // Scan for nframes whole frames plus tail cycles, then go dark. Load mode
  // per frame: 0 none, 1 one load mid-frame, 2 two loads mid-frame (the last
  // one wins), 3 one load mid-frame and one on the frame-boundary edge.
  task automatic run_enabled(input int nframes, input int first_mode, input bit rand_modes, input int tail);
    int e0, fs, mode, off_a, off_b;
    bit ld;
    en = 1'b1;
    e0 = cyc + 1;
    for (int f = 0; f < nframes; f++) begin
      fs = e0 + FRAME * f;
      for (int k = 0; k < 6; k++) push_disp(fs + SCAN * k, 6'b1 << k, k);
      mode  = (f == 0) ? first_mode : (rand_modes ? int'($urandom_range(0, 3)) : 0);
      off_a = $urandom_range(0, 179);
      off_b = $urandom_range(180, FRAME - 2);
      for (int off = 0; off < FRAME; off++) begin
        ld = (mode == 1 && off == off_a) ||
             (mode == 2 && (off == off_a || off == off_b)) ||
             (mode == 3 && (off == off_a || off == FRAME - 1));
        if (off == FRAME - 1) begin
          frame_q.push_back(fs + off);
          if (m_pend) begin
            model_commit();
            upd_q.push_back(fs + off);
          end
        end
        if (ld) begin
          data_in  = rand_data();
          point_in = rand_point();
          load     = 1'b1;
          m_pd_d   = data_in;
          m_pd_p   = point_in;
          m_pend   = 1'b1;
        end
        tick();
        load = 1'b0;
      end
    end
    fs = e0 + FRAME * nframes;
    for (int k = 0; k < 6; k++)
      if (SCAN * k < tail) push_disp(fs + SCAN * k, 6'b1 << k, k);
    repeat (tail) tick();
    en = 1'b0;
    push_disp(fs + tail, 6'h00, 0);
    if (m_pend) begin
      model_commit();
      upd_q.push_back(fs + tail);
    end
    tick();
    tick();
  endtask

  // Monitor: any display change or pulse must match the next expected entry.
  always @(negedge sys_clk) begin
    if (mon_on) begin
      if ({sel, seg} != prev_disp) begin
        if (disp_q.size() == 0) begin
          fail_event("display change", {18'h0, sel, seg});
        end else begin
          exp_d = disp_q.pop_front();
          checkOutput("display edge", cyc, exp_d.cyc);
          checkOutput("sel", {26'h0, sel}, {26'h0, exp_d.sel});
          checkOutput("seg", {24'h0, seg}, {24'h0, exp_d.seg});
          checkOutput("seg no-blank", {24'h0, seg_nb}, {24'h0, exp_d.seg_nb});
        end
      end
      if (frame_done) begin
        if (frame_q.size() == 0) fail_event("frame_done", 1);
        else begin
          exp_c = frame_q.pop_front();
          checkOutput("frame_done edge", cyc, exp_c);
        end
      end
      if (upd_done) begin
        if (upd_q.size() == 0) fail_event("upd_done", 1);
        else begin
          exp_c = upd_q.pop_front();
          checkOutput("upd_done edge", cyc, exp_c);
        end
      end
    end
    prev_disp = {sel, seg};
  end

  task automatic check_dark_idle(input string tag);
    checkOutput({tag, " sel"}, {26'h0, sel}, 32'h0);
    checkOutput({tag, " seg"}, {24'h0, seg}, 32'hFF);
    checkOutput({tag, " frame_done"}, {31'h0, frame_done}, 32'h0);
    checkOutput({tag, " upd_done"}, {31'h0, upd_done}, 32'h0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en        = 1'b1;
    load      = 1'b0;
    data_in   = 24'h0;
    point_in  = 6'h0;
    m_sh_d = '0; m_sh_p = '0; m_pd_d = '0; m_pd_p = '0; m_pend = 1'b0;

    repeat (3) tick();
    check_dark_idle("reset");
    en = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) tick();
    mon_on = 1'b1;

    applyStimulus(24'h012345, 6'b000000);
    run_enabled(2, 0, 1'b0, 0);
    applyStimulus(24'h000000, 6'b000100);
    run_enabled(1, 0, 1'b0, 0);
    applyStimulus(24'hABCDEF, 6'b000000);
    run_enabled(1, 1, 1'b0, 0);
    run_enabled(2, 3, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) applyStimulus(rand_data(), rand_point());
      run_enabled($urandom_range(1, 3), $urandom_range(0, 3), 1'b1, $urandom_range(0, FRAME - 1));
    end

    // Reset in the middle of a scan while a load is still pending.
    mon_on = 1'b0;
    en = 1'b1;
    data_in  = 24'h987654;
    point_in = 6'h3F;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat ($urandom_range(100, 300)) tick();
    #2 sys_rst_n = 1'b0;
    #1 check_dark_idle("mid reset");
    repeat (5) tick();
    check_dark_idle("held reset");
    en = 1'b0;
    sys_rst_n = 1'b1;
    m_sh_d = '0; m_sh_p = '0; m_pd_d = '0; m_pd_p = '0; m_pend = 1'b0;
    repeat (3) tick();
    mon_on = 1'b1;
    repeat (4) tick();
    run_enabled(1, 0, 1'b0, 0);

    checkOutput("display events left", disp_q.size(), 0);
    checkOutput("frame events left", frame_q.size(), 0);
    checkOutput("update events left", upd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
